// File: rtl/adc_stats_pkg.sv
// Shared types and width helpers for the per-channel ADC statistics engine.
package adc_stats_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, ACCUM, FINISH} state_t;

  function automatic int acc_width(int aw, int l2max);
    return aw + l2max + 1;
  endfunction

  function automatic int cnt_width(int l2max);
    return l2max;
  endfunction

  function automatic int sel_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Full-scale codes of a signed aw-bit sample.
  function automatic int fs_max(int aw);
    return (1 << (aw - 1)) - 1;
  endfunction

  function automatic int fs_min(int aw);
    return -(1 << (aw - 1));
  endfunction

endpackage

// File: rtl/adc_beat_reduce.sv
// Reduces one beat of SPC signed samples to sum, min, max and clip count,
// registered once (pipeline stage S2); the valid flag travels alongside.
module adc_beat_reduce import adc_stats_pkg::*; #(
  parameter int SPC = 8,
  parameter int AW  = 14
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  input  logic [SPC-1:0][AW-1:0]           i_samp,
  output logic                             o_valid,
  output logic signed [AW+$clog2(SPC)-1:0] o_sum,
  output logic signed [AW-1:0]             o_min,
  output logic signed [AW-1:0]             o_max,
  output logic [$clog2(SPC):0]             o_clip
);
  localparam int SUM_W  = AW + $clog2(SPC);
  localparam int CLIP_W = $clog2(SPC) + 1;
  localparam logic signed [AW-1:0] FS_POS = AW'(fs_max(AW));
  localparam logic signed [AW-1:0] FS_NEG = AW'(fs_min(AW));

  logic signed [SUM_W-1:0] w_sum;
  logic signed [AW-1:0]    w_min, w_max;
  logic [CLIP_W-1:0]       w_clip;
  logic                    r_valid;
  logic signed [SUM_W-1:0] r_sum;
  logic signed [AW-1:0]    r_min, r_max;
  logic [CLIP_W-1:0]       r_clip;

  always_comb begin
    w_sum  = '0;
    w_min  = FS_POS;
    w_max  = FS_NEG;
    w_clip = '0;
    for (int i = 0; i < SPC; i++) begin
      w_sum = w_sum + SUM_W'($signed(i_samp[i]));
      if ($signed(i_samp[i]) < w_min) w_min = i_samp[i];
      if ($signed(i_samp[i]) > w_max) w_max = i_samp[i];
      if (i_samp[i] == FS_POS || i_samp[i] == FS_NEG) w_clip = w_clip + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
      r_clip  <= '0;
    end else begin
      r_valid <= i_valid;
      r_sum   <= w_sum;
      r_min   <= w_min;
      r_max   <= w_max;
      r_clip  <= w_clip;
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_min   = r_min;
  assign o_max   = r_max;
  assign o_clip  = r_clip;
endmodule

// File: rtl/adc_channel_stats.sv
// Per-channel ADC measurement engine: mux (S1), beat reduce (S2), accumulate (S3),
// with a run FSM producing mean/min/max/clip results per 2^L-sample run.
module adc_channel_stats import adc_stats_pkg::*; #(
  parameter int ADC_COUNT         = 8,
  parameter int ADC_WIDTH         = 14,
  parameter int SAMPLES_PER_CLOCK = 8,
  parameter int AXI_SAMPLE_WIDTH  = 16,
  parameter int LOG2_MAX_COUNT    = 24,
  parameter int RESULT_WIDTH      = 16
) (
  input  logic                                                   adcClk,
  input  logic                                                   adcReset,
  input  logic [ADC_COUNT*SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH-1:0] adcsTDATA,
  input  logic                                                   adcsTVALID,
  input  logic                                                   start,
  input  logic                                                   continuous,
  input  logic [sel_width(ADC_COUNT)-1:0]                        channelSelect,
  input  logic [4:0]                                             log2Count,
  output logic                                                   busy,
  output logic                                                   done,
  output logic                                                   resultValid,
  output logic [RESULT_WIDTH-1:0]                                meanValue,
  output logic [ADC_WIDTH-1:0]                                   minValue,
  output logic [ADC_WIDTH-1:0]                                   maxValue,
  output logic [LOG2_MAX_COUNT:0]                                clipCount
);
  localparam int SPC        = SAMPLES_PER_CLOCK;
  localparam int AW         = ADC_WIDTH;
  localparam int AXW        = AXI_SAMPLE_WIDTH;
  localparam int LSPC       = $clog2(SPC);
  localparam int SEL_W      = sel_width(ADC_COUNT);
  localparam int ACC_W      = acc_width(AW, LOG2_MAX_COUNT);
  localparam int CNT_W      = cnt_width(LOG2_MAX_COUNT);
  localparam int FRAC       = RESULT_WIDTH - ADC_WIDTH;
  localparam int SUM_W      = AW + LSPC;
  localparam int CLIP_ACC_W = LOG2_MAX_COUNT + 1;
  localparam int SLOT_BITS  = SPC * AXW;
  localparam logic signed [AW-1:0] FS_POS = AW'(fs_max(AW));
  localparam logic signed [AW-1:0] FS_NEG = AW'(fs_min(AW));

  state_t                  r_state, w_next;
  logic [SEL_W-1:0]        r_chan;
  logic [4:0]              r_log2, w_l2Clamp;
  logic                    r_flushCnt;
  logic [SLOT_BITS-1:0]    w_slots;
  logic [SPC-1:0][AW-1:0]  w_samp, r_s1Samp;
  logic                    r_s1Valid;
  logic                    w_bValid;
  logic signed [SUM_W-1:0] w_bSum;
  logic signed [AW-1:0]    w_bMin, w_bMax;
  logic [LSPC:0]           w_bClip;
  logic signed [ACC_W-1:0] r_sumAcc;
  logic signed [AW-1:0]    r_minAcc, r_maxAcc;
  logic [CLIP_ACC_W-1:0]   r_clipAcc;
  logic [CNT_W-1:0]        r_beatCnt, w_lastIdx;
  logic                    w_lastBeat, w_latch;
  logic                    w_busy, w_clear, w_accEn, w_finish;
  logic signed [ACC_W+FRAC-1:0] w_scaled;
  logic [RESULT_WIDTH-1:0] w_mean;
  logic                    r_done, r_resValid;
  logic [RESULT_WIDTH-1:0] r_mean;
  logic [AW-1:0]           r_min, r_max;
  logic [CLIP_ACC_W-1:0]   r_clip;

  // S1: channel mux; samples are MSB-aligned in their slots.
  assign w_slots = adcsTDATA[int'(r_chan)*SLOT_BITS +: SLOT_BITS];
  for (genvar g = 0; g < SPC; g++) begin : g_slot
    assign w_samp[g] = w_slots[g*AXW + (AXW-AW) +: AW];
  end

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      r_s1Samp  <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Samp  <= w_samp;
      r_s1Valid <= adcsTVALID;
    end
  end

  adc_beat_reduce #(.SPC(SPC), .AW(AW)) u_reduce (
    .i_clk(adcClk), .i_rst(adcReset), .i_valid(r_s1Valid), .i_samp(r_s1Samp),
    .o_valid(w_bValid), .o_sum(w_bSum), .o_min(w_bMin), .o_max(w_bMax), .o_clip(w_bClip)
  );

  assign w_l2Clamp  = (log2Count < 5'(LSPC)) ? 5'(LSPC) :
                      (log2Count > 5'(LOG2_MAX_COUNT)) ? 5'(LOG2_MAX_COUNT) : log2Count;
  assign w_lastIdx  = (CNT_W'(1) << (r_log2 - 5'(LSPC))) - CNT_W'(1);
  assign w_lastBeat = (r_beatCnt == w_lastIdx);
  assign w_latch    = start || (r_state == FINISH && continuous);

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FLUSH;
      FLUSH:   if (!start && r_flushCnt) w_next = ACCUM;
      ACCUM:   if (start) w_next = FLUSH;
               else if (w_bValid && w_lastBeat) w_next = FINISH;
      FINISH:  w_next = (start || continuous) ? FLUSH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != IDLE);
    w_clear  = (r_state == FLUSH);
    w_accEn  = (r_state == ACCUM) && w_bValid;
    w_finish = (r_state == FINISH);
  end

  // S3 accumulators; FLUSH restarts its two-cycle drain whenever a new latch occurs.
  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      r_chan     <= '0;
      r_log2     <= 5'(LSPC);
      r_flushCnt <= 1'b0;
      r_sumAcc   <= '0;
      r_minAcc   <= FS_POS;
      r_maxAcc   <= FS_NEG;
      r_clipAcc  <= '0;
      r_beatCnt  <= '0;
    end else begin
      if (w_latch) begin
        r_chan <= channelSelect;
        r_log2 <= w_l2Clamp;
      end
      r_flushCnt <= (r_state == FLUSH) && !w_latch;
      if (w_clear) begin
        r_sumAcc  <= '0;
        r_minAcc  <= FS_POS;
        r_maxAcc  <= FS_NEG;
        r_clipAcc <= '0;
        r_beatCnt <= '0;
      end else if (w_accEn) begin
        r_sumAcc  <= r_sumAcc + ACC_W'(w_bSum);
        if (w_bMin < r_minAcc) r_minAcc <= w_bMin;
        if (w_bMax > r_maxAcc) r_maxAcc <= w_bMax;
        r_clipAcc <= r_clipAcc + CLIP_ACC_W'(w_bClip);
        r_beatCnt <= r_beatCnt + 1'b1;
      end
    end
  end

  // Mean = sum * 2^FRAC / 2^L as one arithmetic shift; the result always fits.
  assign w_scaled = {r_sumAcc, {FRAC{1'b0}}};
  assign w_mean   = RESULT_WIDTH'(w_scaled >>> r_log2);

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      r_done     <= 1'b0;
      r_resValid <= 1'b0;
      r_mean     <= '0;
      r_min      <= '0;
      r_max      <= '0;
      r_clip     <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_resValid <= 1'b1;
        r_mean     <= w_mean;
        r_min      <= r_minAcc;
        r_max      <= r_maxAcc;
        r_clip     <= r_clipAcc;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign resultValid = r_resValid;
  assign meanValue   = r_mean;
  assign minValue    = r_min;
  assign maxValue    = r_max;
  assign clipCount   = r_clip;
endmodule

// File: tb/tb_adc_channel_stats.sv
// Directed scoreboard bench: stimulus pushes expected results, a monitor checks each done.
module tb_adc_channel_stats;
  localparam int NA = 8, AW = 14, SPC = 8, AXW = 16, L2M = 24, RW = 16;
  localparam int TW = NA * SPC * AXW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [TW-1:0] adcsTDATA = '0;
  logic          adcsTVALID = 1'b0;
  logic          start = 1'b0, continuous = 1'b0;
  logic [2:0]    channelSelect = '0;
  logic [4:0]    log2Count = '0;
  logic          busy, done, resultValid;
  logic [RW-1:0] meanValue;
  logic [AW-1:0] minValue, maxValue;
  logic [L2M:0]  clipCount;

  adc_channel_stats dut (
    .adcClk(clk), .adcReset(rst), .adcsTDATA(adcsTDATA), .adcsTVALID(adcsTVALID),
    .start(start), .continuous(continuous), .channelSelect(channelSelect),
    .log2Count(log2Count), .busy(busy), .done(done), .resultValid(resultValid),
    .meanValue(meanValue), .minValue(minValue), .maxValue(maxValue), .clipCount(clipCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int mean; int mn; int mx; int clip; int at; } exp_t;
  exp_t expq[$];
  exp_t me;
  int   n_pass = 0, n_total = 0;

  int  g_const[NA];
  bit  g_ramp = 0, g_clip2 = 0, g_rand = 0;
  int  g_rampIdx = 0, g_off = 0;
  bit  vpat[2048];

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive();
    logic [TW-1:0]        d;
    logic signed [AW-1:0] s;
    d = '0;
    for (int k = 0; k < NA; k++)
      for (int i = 0; i < SPC; i++) begin
        if (g_ramp && k == 0) s = AW'(-512 + ((g_rampIdx * SPC + i) % 1024));
        else if (g_clip2 && k == 2) s = (i < 3) ? AW'(8191) : AW'(0);
        else s = AW'(g_const[k]);
        d[(k*SPC+i)*AXW +: AXW] = {s, 2'b01};
      end
    adcsTDATA  = d;
    adcsTVALID = (g_rand && g_off < 2048) ? vpat[g_off] : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    g_off++;
    g_rampIdx++;
    drive();
  endtask

  task automatic kick(int ch, int l2, bit cont, output int c0);
    channelSelect = 3'(ch);
    log2Count     = 5'(l2);
    continuous    = cont;
    start         = 1'b1;
    c0            = cyc;
    g_off         = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic push(int mean, int mn, int mx, int clip, int at);
    exp_t e;
    e.mean = mean; e.mn = mn; e.mx = mx; e.clip = clip; e.at = at;
    expq.push_back(e);
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    repeat (10) tick();
    chk("queue_drained", expq.size(), 0);
    chk("busy_after_run", int'(busy), 0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_resultValid"}, int'(resultValid), 0);
    chk({tag, "_mean"}, int'(meanValue), 0);
    chk({tag, "_min"}, int'(minValue), 0);
    chk({tag, "_max"}, int'(maxValue), 0);
    chk({tag, "_clip"}, int'(clipCount), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (expq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = expq.pop_front();
        chk("mean", int'($signed(meanValue)), me.mean);
        chk("min", int'($signed(minValue)), me.mn);
        chk("max", int'($signed(maxValue)), me.mx);
        chk("clip", int'(clipCount), me.clip);
        chk("done_cycle", cyc, me.at);
        chk("resultValid", int'(resultValid), 1);
      end
    end
  end

  initial begin
    int c0, c1, cntv, olast;
    for (int k = 0; k < NA; k++) g_const[k] = 1000 * k - 3500;
    drive();
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Constant 100 on channel 3, L=10.
    g_const[3] = 100;
    kick(3, 10, 0, c0);
    chk("busy_cycle1", int'(busy), 1);
    push(400, 100, 100, 0, c0 + 132);
    wait_idle(3000);

    // Ramp -512..511 on channel 0, L=10.
    g_ramp = 1;
    kick(0, 10, 0, c0);
    push(-2, -512, 511, 0, c0 + 132);
    wait_idle(3000);
    g_ramp = 0;

    // Random TVALID, constant -7 on channel 6, L=12 (512 valid beats).
    g_const[6] = -7;
    for (int o = 0; o < 2048; o++) vpat[o] = ($urandom_range(0, 1) == 1);
    cntv = 0; olast = 0;
    for (int o = 1; o < 2048; o++)
      if (olast == 0) begin
        cntv += int'(vpat[o]);
        if (cntv == 512) olast = o;
      end
    g_rand = 1;
    kick(6, 12, 0, c0);
    push(-28, -7, -7, 0, c0 + olast + 4);
    wait_idle(3000);
    g_rand = 0;

    // Continuous: channel 2 clips, channel switch mid-run, continuous dropped in run 2.
    g_clip2 = 1;
    g_const[5] = -8192;
    kick(2, 3, 1, c0);
    push(12286, 0, 8191, 3, c0 + 5);
    push(-32768, -8192, -8192, 8, c0 + 9);
    tick();
    channelSelect = 3'd5;
    repeat (3) tick();
    continuous = 1'b0;
    wait_idle(200);
    g_clip2 = 0;

    // Abort in ACCUM: only the restarted run reports.
    g_const[1] = 50;
    g_const[7] = 1234;
    kick(1, 6, 0, c0);
    repeat (5) tick();
    kick(7, 4, 0, c1);
    push(4936, 1234, 1234, 0, c1 + 6);
    wait_idle(200);

    // Start during FINISH: completed run still reports; new run uses clamped L=3.
    g_const[0] = 300;
    g_const[4] = -1;
    kick(0, 3, 0, c0);
    push(1200, 300, 300, 0, c0 + 5);
    repeat (3) tick();
    kick(4, 0, 0, c1);
    push(-4, -1, -1, 0, c1 + 5);
    wait_idle(200);

    // log2Count 31 clamps to a long run; reset mid-run clears everything.
    kick(3, 31, 0, c0);
    repeat (300) tick();
    chk("busy_long_run", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("midrun_reset");
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("queue_after_reset", expq.size(), 0);
    chk("busy_after_reset", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adc_channel_stats.md
# adc_channel_stats

Next-generation per-channel ADC measurement engine in the ADC clock domain. Selects one channel from the packed multi-ADC AXI sample bus and accumulates a programmable power-of-two number of samples (honouring TVALID). Reports mean, minimum, maximum and full-scale clip count per run, in single-shot or continuous mode. Feeds gain/offset/skew calibration software via a CSR wrapper that owns any clock crossing.

## Interface
- ADC_COUNT, 8, number of ADCs on the packed bus
- ADC_WIDTH, 14, significant bits per sample, MSB-aligned in each slot, signed
- SAMPLES_PER_CLOCK, 8, samples per ADC per beat; power of two, >= 2
- AXI_SAMPLE_WIDTH, 16, slot width per sample
- LOG2_MAX_COUNT, 24, largest run length is 2^LOG2_MAX_COUNT samples
- RESULT_WIDTH, 16, mean width; RESULT_WIDTH-ADC_WIDTH fractional bits
- Clock and reset: one clock; reset is asynchronous and active-high.
- adcClk  in  1  sample clock; all logic on rising edge
- adcReset  in  1  asynchronous, active-high reset
- adcsTDATA  in  ADC_COUNT*SAMPLES_PER_CLOCK*AXI_SAMPLE_WIDTH  packed samples, ADC k sample i at slot k*SPC+i
- adcsTVALID  in  1  beat qualifier
- start  in  1  single-cycle run request
- continuous  in  1  rerun automatically after each completed run
- channelSelect  in  clog2(ADC_COUNT)  ADC to measure, latched at run start
- log2Count  in  5  run length exponent, latched at run start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when results update
- resultValid  out  1  set at first done, cleared by reset only
- meanValue  out  RESULT_WIDTH  signed mean
- minValue, maxValue  out  ADC_WIDTH each  signed extremes
- clipCount  out  LOG2_MAX_COUNT+1  samples equal to most-positive or most-negative code

## Operation
- log2Count clamped at latch into [clog2(SAMPLES_PER_CLOCK), LOG2_MAX_COUNT]; run length N = 2^L samples = 2^L/SPC valid beats.
- Pipeline per beat: S1 register selected channel slots plus valid; S2 per-beat reduction (sum, min, max, clip count); S3 accumulate. Valid flag travels with data; invalid beats do not update any accumulator or the beat counter.
- States: IDLE -> FLUSH on start. FLUSH holds 2 cycles (drains S1/S2 from the old channel), clears accumulators (min to +max code, max to -max code, sums/counts to 0) -> ACCUM. ACCUM counts valid beats at S3; on the last beat -> FINISH. FINISH: one cycle, registers results, pulses done -> FLUSH if continuous (re-latching channelSelect/log2Count) else IDLE.
- meanValue = floor(sum * 2^(RESULT_WIDTH-ADC_WIDTH) / 2^L): arithmetic shift of the accumulator, exact; never overflows. Accumulator width ADC_WIDTH+LOG2_MAX_COUNT+1.
- start in FLUSH/ACCUM aborts: no done, restart FLUSH with new latch. start in FINISH: done still pulses with completed results, then FLUSH.
- continuous deassert mid-run: current run completes, then IDLE.
- Outputs hold last results between runs; busy = state != IDLE.

## Timing
- Reset values: busy 0, done 0, resultValid 0, meanValue 0, minValue 0, maxValue 0, clipCount 0, state IDLE.
- start at cycle 0 -> busy 1 at cycle 1. With TVALID held high, done at cycle 3+2^L/SPC+1; results valid the same cycle as done.
- First sample included is the one presented on adcsTDATA at cycle 1 (first beat entering S1 after FLUSH).
- Continuous gap between runs: 3 cycles (FINISH + FLUSH).
- Reset asserted mid-run: immediate return to reset values; no done.

## Structure
- Package adc_stats_pkg: state enum (IDLE, FLUSH, ACCUM, FINISH), width helper functions (accumulator, counter, mux-select widths), full-scale code constants.
- Sub-module adc_beat_reduce: combinational-plus-one-register reduction of SPC samples to beat sum, min, max, clip count (stage S2).
- Top holds the mux, FSM, beat counter, accumulators and result registers.

## Test plan
- Constant 100 on channel 3, L=10, continuous 0 -> one done; meanValue 400, min=max=100, clipCount 0, busy low after.
- Ramp -512..511 repeating, L=10 -> meanValue floor(-0.5*4) = -2, min -512, max 511.
- TVALID 50% random, constant -7, L=12 -> done after exactly 512 valid beats; meanValue -28.
- Channel 2 at +8191 clip on 3 samples per run, continuous, switch channelSelect mid-run -> first run clipCount 3 on channel 2, next run reflects new channel, 3-cycle gap.
- start asserted mid-ACCUM and in FINISH -> no done for aborted run; done pulses in FINISH case with completed values.
- log2Count 0 and 31 -> clamped to 3 and 24; adcReset mid-run -> all outputs 0, no done.
